// File: rtl/ifft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifft_pkg
//  Description : Shared constants and types for the 32-point streaming IFFT
//                SDF pipeline (stages 2, 3 and 4).
//  Revision    : 1.0  initial release
// ============================================================================
package ifft_pkg;

    // Per-component sample widths: S3.9 in, S4.9 out of a radix-2 stage
    localparam int IW   = 13;
    localparam int OW   = 14;

    // Transform length and stage-3 butterfly span
    localparam int N_PT = 32;
    localparam int D3   = 4;

    // SDF stage control states
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } sdf_state_t;

endpackage : ifft_pkg
`default_nettype wire

// File: rtl/sdf_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : sdf_delay_line
//  Description : DEPTH-deep feedback shift register for an SDF butterfly.
//                One push at the tail and one pop at the head per enabled
//                cycle. Contents are not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module sdf_delay_line
    import ifft_pkg::*;
#(
    parameter int DEPTH = D3,
    parameter int WIDTH = 2 * OW
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_tap [DEPTH];

    // Shift every tap one position toward the head when enabled
    always_ff @(posedge clk) begin
        if (en) begin
            r_tap[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_tap[i] <= r_tap[i-1];
            end
        end
    end

    assign dout = r_tap[DEPTH-1];

endmodule : sdf_delay_line
`default_nettype wire

// File: rtl/ifft_stage3_sdf.sv
`default_nettype none
// ============================================================================
//  Module      : ifft_stage3_sdf
//  Description : Radix-2 single-delay-feedback stage 3 of the 32-point IFFT.
//                Pairs samples D apart in each 2D group; UO = U+L leaves
//                immediately, LO = U-L is parked in the delay line and leaves
//                during the next group's first half (or on a flush drain).
//                Optional macro IFFT_STAGE3_OUT_REG_EN adds one more output
//                register stage (latency D+2 instead of D+1).
//  Revision    : 1.0  initial release
// ============================================================================
module ifft_stage3_sdf #(
    parameter int D  = ifft_pkg::D3,
    parameter int N  = ifft_pkg::N_PT,
    parameter int IW = ifft_pkg::IW,
    parameter int OW = ifft_pkg::OW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_real,
    input  logic [IW-1:0] in_imag,
    input  logic          flush,
    output logic          out_valid,
    output logic          out_last,
    output logic [OW-1:0] out_real,
    output logic [OW-1:0] out_imag
);
    import ifft_pkg::*;

    localparam int c_gw = $clog2(2 * D);
    localparam int c_fw = $clog2(N);

    localparam logic [c_gw-1:0] c_grp_last = c_gw'(2 * D - 1);
    localparam logic [c_gw-1:0] c_phase_b  = c_gw'(D);
    localparam logic [c_gw-1:0] c_dm1      = c_gw'(D - 1);
    localparam logic [c_fw-1:0] c_frm_last = c_fw'(N - 1);
    localparam logic [c_fw-1:0] c_frm_dm1  = c_fw'(D - 1);

    sdf_state_t       r_state;
    sdf_state_t       w_state_nxt;
    logic [c_gw-1:0]  r_grp_cnt;
    logic [c_gw-1:0]  r_drain_cnt;
    logic [c_gw-1:0]  w_drain_idx;
    logic [c_fw-1:0]  r_frm_cnt;
    logic             r_pending;

    logic             w_accept;
    logic             w_phase_b;
    logic             w_drain_start;
    logic             w_drain_pop;
    logic             w_drain_last;
    logic             w_shift;

    logic [2*OW-1:0]  w_head;
    logic [2*OW-1:0]  w_tail;
    logic [OW-1:0]    w_head_re, w_head_im;
    logic [OW-1:0]    w_ui_re, w_ui_im;
    logic [OW-1:0]    w_li_re, w_li_im;
    logic [OW-1:0]    w_uo_re, w_uo_im;
    logic [OW-1:0]    w_lo_re, w_lo_im;

    logic             r_out_valid;
    logic             r_out_last;
    logic [OW-1:0]    r_out_real;
    logic [OW-1:0]    r_out_imag;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, input handshake and drain sequencing; a drain starts popping
    // in the same cycle flush is recognised, so in_ready drops in that cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_drain_start = 1'b0;
        w_drain_pop   = 1'b0;
        w_drain_idx   = '0;
        in_ready      = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_drain_start = flush && (r_grp_cnt == '0) && r_pending;
                in_ready      = !w_drain_start;
                w_drain_pop   = w_drain_start;
            end
            ST_DRAIN: begin
                w_drain_pop = 1'b1;
                w_drain_idx = r_drain_cnt;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        w_drain_last = w_drain_pop && (w_drain_idx == c_dm1);
        if (w_drain_pop) begin
            w_state_nxt = w_drain_last ? ST_RUN : ST_DRAIN;
        end
    end

    assign w_accept  = in_valid && in_ready;
    assign w_phase_b = (r_grp_cnt >= c_phase_b);
    assign w_shift   = w_accept || w_drain_pop;

    // Butterfly: the head holds a sign-extended input during phase B, so its
    // low IW bits carry the full value and re-extension is exact
    assign w_head_re = w_head[2*OW-1:OW];
    assign w_head_im = w_head[OW-1:0];
    assign w_ui_re   = {{(OW-IW){w_head_re[IW-1]}}, w_head_re[IW-1:0]};
    assign w_ui_im   = {{(OW-IW){w_head_im[IW-1]}}, w_head_im[IW-1:0]};
    assign w_li_re   = {{(OW-IW){in_real[IW-1]}}, in_real};
    assign w_li_im   = {{(OW-IW){in_imag[IW-1]}}, in_imag};
    assign w_uo_re   = w_ui_re + w_li_re;
    assign w_uo_im   = w_ui_im + w_li_im;
    assign w_lo_re   = w_ui_re - w_li_re;
    assign w_lo_im   = w_ui_im - w_li_im;
    assign w_tail    = w_phase_b ? {w_lo_re, w_lo_im} : {w_li_re, w_li_im};

    sdf_delay_line #(
        .DEPTH (D),
        .WIDTH (2 * OW)
    ) u_delay (
        .clk  (clk),
        .en   (w_shift),
        .din  (w_tail),
        .dout (w_head)
    );

    // Group/frame counters, drain index and the pending-LO flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grp_cnt   <= '0;
            r_frm_cnt   <= '0;
            r_drain_cnt <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grp_cnt <= (r_grp_cnt == c_grp_last) ? '0 : r_grp_cnt + 1'b1;
                r_frm_cnt <= (r_frm_cnt == c_frm_last) ? '0 : r_frm_cnt + 1'b1;
                if (r_grp_cnt == c_dm1) begin
                    r_pending <= 1'b0;
                end
                if (r_grp_cnt == c_grp_last) begin
                    r_pending <= 1'b1;
                end
            end
            if (w_drain_pop) begin
                r_drain_cnt <= w_drain_last ? '0 : w_drain_idx + 1'b1;
                if (w_drain_last) begin
                    r_pending <= 1'b0;
                end
            end
        end
    end

    // Output register. Output frame position is always frm_cnt-D (+drain
    // index), so the frame's last output is either the phase-A pop at
    // frm_cnt==D-1 or the final drain pop at a frame boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_real  <= '0;
            r_out_imag  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_drain_pop) begin
                r_out_real  <= w_head_re;
                r_out_imag  <= w_head_im;
                r_out_valid <= 1'b1;
                r_out_last  <= w_drain_last && (r_frm_cnt == '0);
            end else if (w_accept) begin
                if (w_phase_b) begin
                    r_out_real  <= w_uo_re;
                    r_out_imag  <= w_uo_im;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_real  <= w_head_re;
                    r_out_imag  <= w_head_im;
                    r_out_valid <= r_pending;
                    r_out_last  <= r_pending && (r_frm_cnt == c_frm_dm1);
                end
            end
        end
    end

`ifdef IFFT_STAGE3_OUT_REG_EN
    logic          r_out2_valid;
    logic          r_out2_last;
    logic [OW-1:0] r_out2_real;
    logic [OW-1:0] r_out2_imag;

    // Extra retiming stage in front of the ports
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out2_valid <= 1'b0;
            r_out2_last  <= 1'b0;
            r_out2_real  <= '0;
            r_out2_imag  <= '0;
        end else begin
            r_out2_valid <= r_out_valid;
            r_out2_last  <= r_out_last;
            r_out2_real  <= r_out_real;
            r_out2_imag  <= r_out_imag;
        end
    end

    assign out_valid = r_out2_valid;
    assign out_last  = r_out2_last;
    assign out_real  = r_out2_real;
    assign out_imag  = r_out2_imag;
`else
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_real  = r_out_real;
    assign out_imag  = r_out_imag;
`endif

endmodule : ifft_stage3_sdf
`default_nettype wire

// File: tb/tb_ifft_stage3_sdf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifft_stage3_sdf
//  Description : Directed self-checking bench for ifft_stage3_sdf.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifft_stage3_sdf;

    localparam int D  = 4;
    localparam int N  = 32;
    localparam int IW = 13;
    localparam int OW = 14;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush    = 1'b0;
    logic [IW-1:0] in_real  = '0;
    logic [IW-1:0] in_imag  = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_last;
    logic [OW-1:0] out_real;
    logic [OW-1:0] out_imag;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int oq_re[$];
    int oq_im[$];
    int oq_cyc[$];
    bit oq_last[$];
    int sq_re[$];
    int sq_im[$];
    int eq_re[$];
    int eq_im[$];
    bit eq_last[$];

    ifft_stage3_sdf u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_real  (out_real),
        .out_imag  (out_imag)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every valid output away from the active edge
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            oq_re.push_back(int'($signed(out_real)));
            oq_im.push_back(int'($signed(out_imag)));
            oq_last.push_back(out_last);
            oq_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic clear_queues();
        oq_re.delete(); oq_im.delete(); oq_last.delete(); oq_cyc.delete();
        sq_re.delete(); sq_im.delete();
        eq_re.delete(); eq_im.delete(); eq_last.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_queues();
    endtask

    task automatic send(input int re, input int im);
        in_valid = 1'b1;
        in_real  = IW'(re);
        in_imag  = IW'(im);
        @(negedge clk);
        in_valid = 1'b0;
        sq_re.push_back(re);
        sq_im.push_back(im);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (D + 3) @(negedge clk);
    endtask

    // Golden radix-2 model: per complete 2D group, D sums then D differences
    task automatic model_build();
        eq_re.delete(); eq_im.delete(); eq_last.delete();
        for (int g = 0; g + 2*D <= sq_re.size(); g += 2*D) begin
            for (int k = 0; k < D; k++) begin
                eq_re.push_back(sq_re[g+k] + sq_re[g+k+D]);
                eq_im.push_back(sq_im[g+k] + sq_im[g+k+D]);
            end
            for (int k = 0; k < D; k++) begin
                eq_re.push_back(sq_re[g+k] - sq_re[g+k+D]);
                eq_im.push_back(sq_im[g+k] - sq_im[g+k+D]);
            end
        end
        for (int i = 0; i < eq_re.size(); i++) eq_last.push_back((i % N) == N-1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, out_last, in_ready} !== 3'b001) begin
            bad++;
            $display("FAIL reset_flags got v/l/rdy=%b%b%b exp 001", out_valid, out_last, in_ready);
        end
        total++;
        if (out_real !== '0 || out_imag !== '0) begin
            bad++;
            $display("FAIL reset_data got re=%h im=%h exp 0", out_real, out_imag);
        end
        rst_n = 1'b1;
        @(negedge clk);
        clear_queues();
    endtask

    task automatic test_single_group();
        int s;
        int exp_re[8] = '{6, 8, 10, 12, -4, -4, -4, -4};
        do_reset();
        s = cyc;
        for (int k = 1; k <= 8; k++) send(k, 0);
        do_flush();
        total++;
        if (oq_re.size() != 8) begin
            bad++;
            $display("FAIL single_count got=%0d exp=8", oq_re.size());
        end
        for (int i = 0; i < 8 && i < oq_re.size(); i++) begin
            total++;
            if (oq_re[i] !== exp_re[i] || oq_im[i] !== 0 || oq_last[i] !== 1'b0 || oq_cyc[i] !== s + 5 + i) begin
                bad++;
                $display("FAIL single_out[%0d] got re=%0d im=%0d last=%0b cyc=%0d exp re=%0d im=0 last=0 cyc=%0d",
                         i, oq_re[i], oq_im[i], oq_last[i], oq_cyc[i], exp_re[i], s + 5 + i);
            end
        end
        total++;
        if (out_valid !== 1'b0 || out_real !== 14'h3FFC) begin
            bad++;
            $display("FAIL single_hold got v=%b re=%h exp v=0 re=3ffc", out_valid, out_real);
        end
    endtask

    task automatic test_extremes();
        int xr[8]    = '{-4096, 4095, 0, 0, -4096, -4096, 0, 0};
        int xi[8]    = '{4095, -4096, 0, 0, -4096, -4096, 0, 0};
        int exp_re[8] = '{-8192, -1, 0, 0, 0, 8191, 0, 0};
        int exp_im[8] = '{-1, -8192, 0, 0, 8191, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 8; k++) send(xr[k], xi[k]);
        do_flush();
        total++;
        if (oq_re.size() != 8) begin
            bad++;
            $display("FAIL extreme_count got=%0d exp=8", oq_re.size());
        end
        for (int i = 0; i < 8 && i < oq_re.size(); i++) begin
            total++;
            if (oq_re[i] !== exp_re[i] || oq_im[i] !== exp_im[i]) begin
                bad++;
                $display("FAIL extreme_out[%0d] got re=%0d im=%0d exp re=%0d im=%0d",
                         i, oq_re[i], oq_im[i], exp_re[i], exp_im[i]);
            end
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        for (int k = 0; k < N; k++) send(k, -k);
        do_flush();
        model_build();
        total++;
        if (oq_re.size() != eq_re.size()) begin
            bad++;
            $display("FAIL frame_count got=%0d exp=%0d", oq_re.size(), eq_re.size());
        end
        for (int i = 0; i < eq_re.size() && i < oq_re.size(); i++) begin
            total++;
            if (oq_re[i] !== eq_re[i] || oq_im[i] !== eq_im[i] || oq_last[i] !== eq_last[i]) begin
                bad++;
                $display("FAIL frame_out[%0d] got re=%0d im=%0d last=%0b exp re=%0d im=%0d last=%0b",
                         i, oq_re[i], oq_im[i], oq_last[i], eq_re[i], eq_im[i], eq_last[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s;
        int late;
        do_reset();
        s = cyc;
        for (int k = 0; k < 2*N; k++) send(3*k - 50, 40 - 2*k);
        do_flush();
        model_build();
        total++;
        if (oq_re.size() != eq_re.size()) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=%0d", oq_re.size(), eq_re.size());
        end
        for (int i = 0; i < eq_re.size() && i < oq_re.size(); i++) begin
            total++;
            if (oq_re[i] !== eq_re[i] || oq_im[i] !== eq_im[i] || oq_last[i] !== eq_last[i]) begin
                bad++;
                $display("FAIL b2b_out[%0d] got re=%0d im=%0d last=%0b exp re=%0d im=%0d last=%0b",
                         i, oq_re[i], oq_im[i], oq_last[i], eq_re[i], eq_im[i], eq_last[i]);
            end
        end
        late = -1;
        for (int i = 0; i < oq_cyc.size(); i++) begin
            if (late < 0 && oq_cyc[i] != s + 5 + i) late = i;
        end
        total++;
        if (late >= 0) begin
            bad++;
            $display("FAIL b2b_timing out[%0d] got cyc=%0d exp cyc=%0d", late, oq_cyc[late], s + 5 + late);
        end
    endtask

    task automatic test_gapped();
        do_reset();
        for (int k = 0; k < N; k++) begin
            send(k, -k);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL gap_idle[%0d] got out_valid=%b exp 0", k, out_valid);
            end
        end
        do_flush();
        model_build();
        total++;
        if (oq_re.size() != eq_re.size()) begin
            bad++;
            $display("FAIL gap_count got=%0d exp=%0d", oq_re.size(), eq_re.size());
        end
        for (int i = 0; i < eq_re.size() && i < oq_re.size(); i++) begin
            total++;
            if (oq_re[i] !== eq_re[i] || oq_im[i] !== eq_im[i] || oq_last[i] !== eq_last[i]) begin
                bad++;
                $display("FAIL gap_out[%0d] got re=%0d im=%0d last=%0b exp re=%0d im=%0d last=%0b",
                         i, oq_re[i], oq_im[i], oq_last[i], eq_re[i], eq_im[i], eq_last[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int k = 0; k < 5; k++) send(100 + k, 7);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_real !== '0 || out_imag !== '0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_state got v=%b re=%h im=%h rdy=%b exp v=0 re=0 im=0 rdy=1",
                     out_valid, out_real, out_imag, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        clear_queues();
        flush = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pending got in_ready=%b exp 1", in_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        for (int k = 0; k < 8; k++) send(10 * k - 30, k);
        do_flush();
        model_build();
        total++;
        if (oq_re.size() != eq_re.size()) begin
            bad++;
            $display("FAIL midrst_count got=%0d exp=%0d", oq_re.size(), eq_re.size());
        end
        for (int i = 0; i < eq_re.size() && i < oq_re.size(); i++) begin
            total++;
            if (oq_re[i] !== eq_re[i] || oq_im[i] !== eq_im[i]) begin
                bad++;
                $display("FAIL midrst_out[%0d] got re=%0d im=%0d exp re=%0d im=%0d",
                         i, oq_re[i], oq_im[i], eq_re[i], eq_im[i]);
            end
        end
    endtask

    task automatic test_flush_cases();
        do_reset();
        for (int k = 0; k < 10; k++) send(5 * k + 1, 20 - k);
        flush = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_midgroup got in_ready=%b exp 1", in_ready);
        end
        for (int k = 10; k < 16; k++) send(5 * k + 1, 20 - k);
        in_valid = 1'b1;
        in_real  = IW'(999);
        in_imag  = IW'(999);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_collide got in_ready=%b exp 0", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (D + 3) @(negedge clk);
        model_build();
        total++;
        if (oq_re.size() != eq_re.size()) begin
            bad++;
            $display("FAIL flush_count got=%0d exp=%0d", oq_re.size(), eq_re.size());
        end
        for (int i = 0; i < eq_re.size() && i < oq_re.size(); i++) begin
            total++;
            if (oq_re[i] !== eq_re[i] || oq_im[i] !== eq_im[i] || oq_last[i] !== eq_last[i]) begin
                bad++;
                $display("FAIL flush_out[%0d] got re=%0d im=%0d last=%0b exp re=%0d im=%0d last=%0b",
                         i, oq_re[i], oq_im[i], oq_last[i], eq_re[i], eq_im[i], eq_last[i]);
            end
        end
        flush = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_after_drain got in_ready=%b exp 1", in_ready);
        end
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_extremes();
        test_full_frame();
        test_back_to_back();
        test_gapped();
        test_reset_mid_frame();
        test_flush_cases();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ifft_stage3_sdf
`default_nettype wire
